// File: rtl/muldiv_if.sv
// Handshake bundle between the EX stage and the iterative multiply/divide unit.
interface muldiv_if #(parameter int XLEN = 32);
    logic            start;
    logic            flush;
    logic [2:0]      funct3;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            stall;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (output start, flush, funct3, a, b, input stall, done, result);
    modport slave  (input start, flush, funct3, a, b, output stall, done, result);
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: shift-add multiply, restoring divide, UNROLL bits per cycle.
// Holds the pipeline with stall until the single-cycle done pulse.
module muldiv_unit #(
    parameter int XLEN   = 32,
    parameter int UNROLL = 1
) (
    input logic     clk,
    input logic     reset,
    muldiv_if.slave bus
);
    localparam int STEPS = XLEN / UNROLL;
    localparam int CW    = $clog2(STEPS + 1);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] PREP = 3'd1;
    localparam logic [2:0] CALC = 3'd2;
    localparam logic [2:0] FIX  = 3'd3;
    localparam logic [2:0] DONE = 3'd4;

    logic [2:0]        state;
    logic [2:0]        f3;
    logic [XLEN-1:0]   a_q, b_q;
    logic [XLEN-1:0]   mcand;
    logic [2*XLEN-1:0] prod;
    logic [XLEN:0]     rem;
    logic [CW-1:0]     cnt;
    logic              sign_a, sign_b;
    logic              done_q;
    logic [XLEN-1:0]   res_q;

    logic              is_div, a_signed, b_signed, sa, sb, div_zero, ovf;
    logic [XLEN-1:0]   a_mag, b_mag, special_res, fix_res;
    logic [XLEN-1:0]   quo, quo_s, rem_s;
    logic [2*XLEN-1:0] prod_s;

    assign is_div   = f3[2];
    assign a_signed = (f3 == 3'b001) || (f3 == 3'b010) || (f3 == 3'b100) || (f3 == 3'b110);
    assign b_signed = (f3 == 3'b001) || (f3 == 3'b100) || (f3 == 3'b110);
    assign sa       = a_signed & a_q[XLEN-1];
    assign sb       = b_signed & b_q[XLEN-1];
    // Negating the most-negative value yields 2^(XLEN-1) read as unsigned.
    assign a_mag    = sa ? -a_q : a_q;
    assign b_mag    = sb ? -b_q : b_q;

    assign div_zero = is_div && (b_q == '0);
    assign ovf      = ((f3 == 3'b100) || (f3 == 3'b110)) && (a_q == MOST_NEG) && (&b_q);
    // f3[1] separates REM/REMU from DIV/DIVU.
    assign special_res = f3[1] ? (div_zero ? a_q : '0) : (div_zero ? '1 : a_q);

    // One CALC cycle worth of iterations; prod low half doubles as the quotient shifter.
    logic [2*XLEN-1:0] p_n;
    logic [XLEN:0]     r_n;
    logic [XLEN:0]     hi;
    always_comb begin
        p_n = prod;
        r_n = rem;
        hi  = '0;
        for (int u = 0; u < UNROLL; u++) begin
            if (is_div) begin
                r_n = {r_n[XLEN-1:0], p_n[XLEN-1]};
                p_n = {p_n[2*XLEN-1:XLEN], p_n[XLEN-2:0], 1'b0};
                if (r_n >= {1'b0, mcand}) begin
                    r_n    = r_n - {1'b0, mcand};
                    p_n[0] = 1'b1;
                end
            end else begin
                hi  = {1'b0, p_n[2*XLEN-1:XLEN]} + (p_n[0] ? {1'b0, mcand} : '0);
                p_n = {hi, p_n[XLEN-1:1]};
            end
        end
    end

    assign prod_s  = (sign_a ^ sign_b) ? -prod : prod;
    assign quo     = prod[XLEN-1:0];
    assign quo_s   = (sign_a ^ sign_b) ? -quo : quo;
    assign rem_s   = sign_a ? -rem[XLEN-1:0] : rem[XLEN-1:0];
    assign fix_res = is_div ? (f3[1] ? rem_s : quo_s)
                            : ((f3[1:0] == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN]);

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            f3     <= '0;
            a_q    <= '0;
            b_q    <= '0;
            mcand  <= '0;
            prod   <= '0;
            rem    <= '0;
            cnt    <= '0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            done_q <= 1'b0;
            res_q  <= '0;
        end else begin
            done_q <= 1'b0;
            if (bus.flush && state != IDLE) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: if (bus.start && !bus.flush) begin
                        state <= PREP;
                        f3    <= bus.funct3;
                        a_q   <= bus.a;
                        b_q   <= bus.b;
                    end
                    PREP: begin
                        sign_a <= sa;
                        sign_b <= sb;
                        cnt    <= CW'(STEPS);
                        rem    <= '0;
                        if (is_div) begin
                            prod  <= {{XLEN{1'b0}}, a_mag};
                            mcand <= b_mag;
                        end else begin
                            prod  <= {{XLEN{1'b0}}, b_mag};
                            mcand <= a_mag;
                        end
                        if (div_zero || ovf) begin
                            res_q  <= special_res;
                            done_q <= 1'b1;
                            state  <= DONE;
                        end else begin
                            state <= CALC;
                        end
                    end
                    CALC: begin
                        prod <= p_n;
                        rem  <= r_n;
                        cnt  <= cnt - CW'(1);
                        if (cnt == CW'(1)) state <= FIX;
                    end
                    FIX: begin
                        res_q  <= fix_res;
                        done_q <= 1'b1;
                        state  <= DONE;
                    end
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // No flush term for busy states: stall releases the cycle after flush.
    assign bus.stall  = !reset && ((bus.start && state == IDLE && !bus.flush) ||
                                   state == PREP || state == CALC || state == FIX);
    assign bus.done   = done_q;
    assign bus.result = res_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: UNROLL=1 and UNROLL=4 instances, latency and result checks.
module tb_muldiv_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        st  = 1'b0;
    logic        fl  = 1'b0;
    logic        sel = 1'b0;
    logic [2:0]  f3  = '0;
    logic [31:0] av  = '0;
    logic [31:0] bv  = '0;
    int          vecs = 0;
    int          errs = 0;

    always #5 clk = ~clk;

    muldiv_if #(.XLEN(32)) i1 ();
    muldiv_if #(.XLEN(32)) i4 ();

    assign i1.start  = st & ~sel;
    assign i4.start  = st & sel;
    assign i1.flush  = fl;
    assign i4.flush  = fl;
    assign i1.funct3 = f3;
    assign i4.funct3 = f3;
    assign i1.a      = av;
    assign i4.a      = av;
    assign i1.b      = bv;
    assign i4.b      = bv;

    muldiv_unit #(.XLEN(32), .UNROLL(1)) u1 (.clk(clk), .reset(rst), .bus(i1));
    muldiv_unit #(.XLEN(32), .UNROLL(4)) u4 (.clk(clk), .reset(rst), .bus(i4));

    logic        stall_o, done_o;
    logic [31:0] res_o;
    assign stall_o = sel ? i4.stall  : i1.stall;
    assign done_o  = sel ? i4.done   : i1.done;
    assign res_o   = sel ? i4.result : i1.result;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Enters just after a rising edge; that cycle is the accept cycle T.
    task automatic op(input string tag, input logic [2:0] f, input logic [31:0] x, input logic [31:0] y,
                      input logic [31:0] exp, input int lat, input bit idle_chk);
        int n;
        bit got, stl_bad;
        n = 0; got = 0; stl_bad = 0;
        f3 = f; av = x; bv = y; st = 1'b1;
        while (!got && n < 100) begin
            @(negedge clk);
            if (done_o) got = 1;
            else begin
                if (!stall_o) stl_bad = 1;
                @(posedge clk); #1;
                n++;
            end
        end
        check({tag, "_done"}, 32'(got), 32'd1);
        check({tag, "_lat"}, n, lat);
        check({tag, "_res"}, res_o, exp);
        check({tag, "_stall"}, {31'b0, stl_bad | stall_o}, 32'd0);
        @(posedge clk); #1;
        st = 1'b0;
        if (idle_chk) begin
            @(negedge clk);
            check({tag, "_idle"}, {30'b0, stall_o, done_o}, 32'd0);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        bit seen;
        // Reset with start held: stall must stay low.
        st = 1'b1;
        @(negedge clk);
        check("rst_stall", {31'b0, i1.stall}, 32'd0);
        check("rst_done",  {31'b0, i1.done},  32'd0);
        check("rst_res",   i1.result,         32'd0);
        check("rst_res4",  i4.result,         32'd0);
        @(posedge clk); #1;
        rst = 1'b0; st = 1'b0;
        @(negedge clk);
        check("post_rst", {30'b0, stall_o, done_o}, 32'd0);
        @(posedge clk); #1;

        op("mul",    3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 35, 1);
        op("mulh",   3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 35, 1);
        op("mulhu",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 35, 1);
        op("mulhsu", 3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 35, 1);
        op("divu",   3'b101, 32'd100,      32'd7,        32'd14,       35, 0);
        op("remu",   3'b111, 32'd100,      32'd7,        32'd2,        35, 1);
        op("div",    3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 35, 1);
        op("rem",    3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 35, 1);
        op("div0",   3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, 2,  1);
        op("rem0",   3'b110, 32'd5,        32'd0,        32'd5,        2,  1);
        op("removf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        2,  1);
        op("divovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 2,  1);

        // Flush in the 10th CALC cycle (T+11) of a DIV.
        f3 = 3'b100; av = 32'd1000; bv = 32'd3; st = 1'b1;
        repeat (11) begin @(posedge clk); #1; end
        fl = 1'b1;
        @(negedge clk);
        check("flush_busy_stall", {31'b0, stall_o}, 32'd1);
        @(posedge clk); #1;
        fl = 1'b0; st = 1'b0;
        @(negedge clk);
        check("flush_stall", {31'b0, stall_o}, 32'd0);
        check("flush_res",   res_o,            32'h80000000);
        seen = done_o;
        repeat (40) begin
            @(posedge clk); #1;
            @(negedge clk);
            seen = seen | done_o;
        end
        check("flush_nodone", {31'b0, seen}, 32'd0);
        @(posedge clk); #1;

        // start together with flush in IDLE is not accepted.
        st = 1'b1; fl = 1'b1;
        @(negedge clk);
        check("stfl_stall", {31'b0, stall_o}, 32'd0);
        @(posedge clk); #1;
        st = 1'b0; fl = 1'b0;
        @(negedge clk);
        check("stfl_idle", {31'b0, stall_o}, 32'd0);
        @(posedge clk); #1;

        op("mul34", 3'b000, 32'd3, 32'd4, 32'd12, 35, 1);

        // Reset mid-CALC.
        f3 = 3'b100; av = 32'd50; bv = 32'd7; st = 1'b1;
        repeat (12) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(negedge clk);
        check("midrst_stall", {31'b0, stall_o}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; st = 1'b0;
        @(negedge clk);
        check("midrst_done",  {31'b0, done_o},  32'd0);
        check("midrst_res",   res_o,            32'd0);
        check("midrst_idle",  {31'b0, stall_o}, 32'd0);
        @(posedge clk); #1;

        sel = 1'b1;
        op("u4_mul",  3'b000, 32'h12345678, 32'h10, 32'h23456780, 11, 1);
        op("u4_divu", 3'b101, 32'hFFFFFFFF, 32'd3,  32'h55555555, 11, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
